// File: rtl/led_mode_sequencer.sv
// DE2 red-LED shift sequencer: one debounced key selects the shift mode.
// Optional bounce mode is compiled in with LED_SEQ_BOUNCE_EN.
module led_mode_sequencer #(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50Mhz,
  input  logic       RESET_N,
  input  logic       KEY,
  input  logic [1:0] SW,
  output logic [7:0] LEDR,
  output logic [1:0] MODE,
  output logic [3:0] HOLD_SEC,
  output logic       BUSY
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] TICK_N =
    TW'(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] M_FREEZE = 2'd0;
  localparam logic [1:0] M_LEFT   = 2'd1;
  localparam logic [1:0] M_RIGHT  = 2'd2;
  localparam logic [1:0] M_BOUNCE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_DECIDE
  } state_t;

  state_t state;
  state_t state_nx;

  logic          k_meta;
  logic          k_sync;
  logic          key_db;
  logic [DW-1:0] db_cnt;
  logic          db_flip;
  logic          press_evt;
  logic          rel_evt;

  logic [TW-1:0] base_cnt;
  logic          base_tick;
  logic [TW-1:0] step_cnt;
  logic [TW-1:0] step_last;
  logic          step_tick;

  logic          hold_clr;
  logic          hold_inc;
  logic          mode_ld;
  logic [1:0]    mode_nx;
  logic [7:0]    led_nx;

  // Key is active-low; the synchroniser idles at "released".
  assign db_flip   = (k_sync != key_db) &&
                     (db_cnt == DEB_LAST);
  assign press_evt = db_flip & ~k_sync;
  assign rel_evt   = db_flip &  k_sync;

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      k_meta <= 1'b1;
      k_sync <= 1'b1;
      key_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      k_meta <= KEY;
      k_sync <= k_meta;
      if (k_sync == key_db) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        key_db <= k_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  assign base_tick = (base_cnt == TICK_LAST);

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      base_cnt <= '0;
    end else if (press_evt || base_tick) begin
      base_cnt <= '0;
    end else begin
      base_cnt <= base_cnt + TW'(1);
    end
  end

  // A speed change can leave the count past the new terminal value.
  assign step_last = (TICK_N >> SW) - TW'(1);
  assign step_tick = (step_cnt == step_last);

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      step_cnt <= '0;
    end else if (step_cnt >= step_last) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + TW'(1);
    end
  end

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (press_evt) state_nx = S_PRESSED;
      S_PRESSED:
        if (rel_evt) state_nx = S_DECIDE;
      S_DECIDE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    hold_clr = 1'b0;
    hold_inc = 1'b0;
    mode_ld  = 1'b0;
    BUSY     = 1'b0;
    unique case (state)
      S_IDLE: begin
        hold_clr = press_evt;
      end
      S_PRESSED: begin
        BUSY     = 1'b1;
        hold_inc = base_tick & ~rel_evt;
      end
      S_DECIDE: begin
        BUSY    = 1'b1;
        mode_ld = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      HOLD_SEC <= 4'd0;
    end else if (hold_clr) begin
      HOLD_SEC <= 4'd0;
    end else if (hold_inc && HOLD_SEC != 4'd15) begin
      HOLD_SEC <= HOLD_SEC + 4'd1;
    end
  end

  always_comb begin
    mode_nx = M_FREEZE;
    unique case (1'b1)
      (HOLD_SEC == 4'd0):
        mode_nx = M_FREEZE;
      (HOLD_SEC inside {[4'd1:4'd3]}):
        mode_nx = M_LEFT;
`ifdef LED_SEQ_BOUNCE_EN
      (HOLD_SEC inside {[4'd4:4'd6]}):
        mode_nx = M_RIGHT;
      (HOLD_SEC >= 4'd7):
        mode_nx = M_BOUNCE;
`else
      (HOLD_SEC >= 4'd4):
        mode_nx = M_RIGHT;
`endif
      default:
        mode_nx = M_FREEZE;
    endcase
  end

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      MODE <= M_LEFT;
    end else if (mode_ld) begin
      MODE <= mode_nx;
    end
  end

`ifdef LED_SEQ_BOUNCE_EN
  logic dir_left;
  logic bnc_left;

  // Direction turns on the tick that leaves an end position.
  assign bnc_left = (LEDR == 8'h01) ? 1'b1 :
                    (LEDR == 8'h80) ? 1'b0 :
                    dir_left;

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      dir_left <= 1'b1;
    end else if (mode_ld && mode_nx == M_BOUNCE &&
                 MODE != M_BOUNCE) begin
      dir_left <= 1'b1;
    end else if (step_tick && MODE == M_BOUNCE &&
                 LEDR != 8'h00) begin
      dir_left <= bnc_left;
    end
  end
`endif

  always_comb begin
    led_nx = LEDR;
    if (LEDR == 8'h00) begin
      led_nx = 8'h01;
    end else begin
      unique case (MODE)
        M_LEFT:
          led_nx = {LEDR[6:0], LEDR[7]};
        M_RIGHT:
          led_nx = {LEDR[0], LEDR[7:1]};
`ifdef LED_SEQ_BOUNCE_EN
        M_BOUNCE:
          led_nx = bnc_left ? {LEDR[6:0], 1'b0}
                            : {1'b0, LEDR[7:1]};
`endif
        default:
          led_nx = LEDR;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50Mhz or negedge RESET_N) begin
    if (!RESET_N) begin
      LEDR <= 8'h01;
    end else if (step_tick) begin
      LEDR <= led_nx;
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: reference model predicts output changes,
// monitor matches every observed change against the expected queue.
module tb_led_mode_sequencer;

  localparam int T = 16;
  localparam int D = 4;
`ifdef LED_SEQ_BOUNCE_EN
  localparam int LONG_MODE = 3;
`else
  localparam int LONG_MODE = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b1;
  logic [1:0] sw = 2'b00;
  logic [7:0] ledr;
  logic [1:0] mode;
  logic [3:0] hold;
  logic       busy;

  led_mode_sequencer #(
    .TICK_CYCLES(T),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLOCK_50Mhz(clk),
    .RESET_N(rst_n),
    .KEY(key),
    .SW(sw),
    .LEDR(ledr),
    .MODE(mode),
    .HOLD_SEC(hold),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [14:0] v;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state: LED as a position, key as a sample history.
  bit         hist[$];
  bit         m_db;
  bit         m_pressed;
  bit         m_decide;
  bit         m_left;
  int         m_p;
  int         m_pos;
  int         m_ph;
  logic [1:0] m_mode;
  logic [3:0] m_hold;
  logic       m_busy;
  logic [14:0] m_prev;

  function automatic logic [1:0] classify(int h);
    if (h == 0) return 2'd0;
    if (h < 4) return 2'd1;
`ifdef LED_SEQ_BOUNCE_EN
    if (h >= 7) return 2'd3;
`endif
    return 2'd2;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(1'b1);
    m_db = 1; m_pressed = 0; m_decide = 0; m_left = 1;
    m_p = 0; m_pos = 0; m_ph = 0;
    m_mode = 2'd1; m_hold = 4'd0; m_busy = 1'b0;
    m_prev = {8'h01, 2'd1, 4'd0, 1'b0};
  endtask

  task automatic model_step();
    bit all0, all1, tick;
    int per, q;
    logic [1:0] old_mode;
    logic [7:0] lv;
    logic [14:0] v;
    hist.push_front(key);
    void'(hist.pop_back());
    all0 = 1; all1 = 1;
    for (int i = 2; i <= D + 1; i++) begin
      if (hist[i]) all0 = 0;
      else all1 = 0;
    end
    per = T >> sw;
    tick = (m_ph == per - 1);
    m_ph = (m_ph >= per - 1) ? 0 : m_ph + 1;
    old_mode = m_mode;
    if (tick) begin
      case (old_mode)
        2'd1: m_pos = (m_pos + 1) % 8;
        2'd2: m_pos = (m_pos + 7) % 8;
        2'd3: begin
          if (m_pos == 7) m_left = 0;
          else if (m_pos == 0) m_left = 1;
          m_pos = m_left ? m_pos + 1 : m_pos - 1;
        end
        default: ;
      endcase
    end
    if (m_decide) begin
      m_decide = 0;
      m_busy = 0;
      m_mode = classify(int'(m_hold));
      if (m_mode == 2'd3 && old_mode != 2'd3) m_left = 1;
    end
    if (m_db && all0) begin
      m_db = 0; m_pressed = 1; m_p = cyc;
      m_hold = 4'd0; m_busy = 1'b1;
    end else if (!m_db && all1) begin
      m_db = 1;
      if (m_pressed) begin
        m_pressed = 0;
        m_decide = 1;
      end
    end else if (m_pressed) begin
      q = (cyc - m_p) / T;
      m_hold = 4'(q > 15 ? 15 : q);
    end
    lv = 8'd1 << m_pos;
    v = {lv, m_mode, m_hold, m_busy};
    if (v != m_prev) begin
      exp_q.push_back('{cyc, v});
      m_prev = v;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
  end

  logic [14:0] last;

  always @(negedge clk) begin : monitor
    logic [14:0] now;
    ev_t e;
    now = {ledr, mode, hold, busy};
    if (!rst_n) begin
      exp_q.delete();
      last = now;
    end else begin
      if (now !== last) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%h expected=none",
                   cyc, now);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== now) begin
            failures++;
            $display("FAIL output_event got cyc=%0d val=%h expected cyc=%0d val=%h",
                     cyc, now, e.cyc, e.v);
          end
        end
        last = now;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event at cyc=%0d got=%h expected cyc=%0d val=%h",
                 cyc, now, exp_q[0].cyc, exp_q[0].v);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic press(int n);
    @(negedge clk);
    key = 1'b0;
    repeat (n) @(negedge clk);
    key = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    int seen;
    logic [7:0] prev;

    repeat (3) @(negedge clk);
    chk("reset_ledr", ledr, 8'h01);
    chk("reset_mode", mode, 1);
    chk("reset_hold", hold, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    repeat (64) @(negedge clk);

    press(20);
    chk("p20_hold", hold, 1);
    chk("p20_mode", mode, 1);

    press(70);
    chk("p70_hold", hold, 4);
    chk("p70_mode", mode, 2);
    repeat (20) @(negedge clk);

    press(120);
    chk("p120_hold", hold, 7);
    chk("p120_mode", mode, LONG_MODE);
    repeat (T * 18) @(negedge clk);

    sw = 2'b11;
    repeat (20) @(negedge clk);
    sw = 2'b00;
    n = 0;
    prev = ledr;
    while (ledr == prev && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sw_back_latency_le16", int'(n <= 16), 1);

    @(negedge clk);
    key = 1'b0;
    repeat (3) @(negedge clk);
    key = 1'b1;
    seen = 0;
    repeat (D + 6) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("glitch_busy", seen, 0);
    chk("glitch_mode", mode, LONG_MODE);

    press(10);
    chk("p10_hold", hold, 0);
    chk("p10_mode", mode, 0);
    repeat (40) @(negedge clk);

    press(20);
    chk("p20b_mode", mode, 1);

    @(negedge clk);
    key = 1'b0;
    n = 0;
    while (hold != 4'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_hold3_in_time", int'(n < 100), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ledr", ledr, 8'h01);
    chk("midreset_mode", mode, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_hold", hold, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (D + 1) @(negedge clk);
    chk("held_key_not_yet", busy, 0);
    @(negedge clk);
    chk("held_key_accepted", busy, 1);
    key = 1'b1;
    repeat (D + 6) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) sw = 2'($urandom_range(0, 3));
      key = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 100)) @(negedge clk);
    end
    key = 1'b1;
    repeat (200) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
